// File: rtl/fwd_clk_ctrl.sv
// fwd_clk_ctrl: produces the D0/D1 half-cycle bits for a DDR output register
// that forwards a 50%-duty clock of period DIV clk cycles to a device pin.
// Starts, stops and ratio changes happen only on whole output periods.
module fwd_clk_ctrl #(
    parameter int unsigned DIV_WIDTH  = 8,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 d0,
    output logic                 d1,
    output logic                 running,
    output logic                 period_done,
    output logic [DIV_WIDTH-1:0] active_div
);

    // Phase counts half-cycles up to 2N-1, so it needs one bit more than div.
    localparam int unsigned PH_W = DIV_WIDTH + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PH_W-1:0]      r_ph;        // phase of the next pair to emit
    logic [PH_W-1:0]      w_ph_nxt;
    logic [DIV_WIDTH-1:0] r_div;       // ratio used for the next pair
    logic [DIV_WIDTH-1:0] w_div_nxt;

    logic                 w_d0_nxt;
    logic                 w_d1_nxt;
    logic                 w_pd_nxt;
    logic                 w_run_nxt;
    logic [DIV_WIDTH-1:0] w_act_nxt;

    logic [DIV_WIDTH-1:0] w_div_eff;
    logic [DIV_WIDTH-1:0] w_n;
    logic [PH_W-1:0]      w_ph;
    logic [PH_W-1:0]      w_ph_inc;
    logic [PH_W-1:0]      w_two_n;
    logic                 w_emit;
    logic                 w_boundary;

    // A ratio of zero is treated as one.
    assign w_div_eff = (div == '0) ? DIV_WIDTH'(1) : div;

    // State, phase and registered pin bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ph        <= '0;
            r_div       <= DIV_WIDTH'(1);
            d0          <= IDLE_LEVEL;
            d1          <= IDLE_LEVEL;
            running     <= 1'b0;
            period_done <= 1'b0;
            active_div  <= DIV_WIDTH'(1);
        end else begin
            r_state     <= w_state_nxt;
            r_ph        <= w_ph_nxt;
            r_div       <= w_div_nxt;
            d0          <= w_d0_nxt;
            d1          <= w_d1_nxt;
            running     <= w_run_nxt;
            period_done <= w_pd_nxt;
            active_div  <= w_act_nxt;
        end
    end

    // Next state and the pair to drive; a start emits phase 0 immediately so
    // the first pair lands one cycle after en is sampled.
    always_comb begin
        w_state_nxt = r_state;
        w_ph_nxt    = r_ph;
        w_div_nxt   = r_div;
        w_d0_nxt    = IDLE_LEVEL;
        w_d1_nxt    = IDLE_LEVEL;
        w_pd_nxt    = 1'b0;
        w_run_nxt   = 1'b0;
        w_act_nxt   = active_div;
        w_emit      = 1'b0;
        w_n         = r_div;
        w_ph        = r_ph;
        w_ph_inc    = '0;
        w_two_n     = '0;
        w_boundary  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_emit = 1'b1;
                    w_n    = w_div_eff;
                    w_ph   = '0;
                end
            end
            ST_RUN: begin
                w_emit = 1'b1;
                w_n    = r_div;
                w_ph   = r_ph;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_emit) begin
            w_ph_inc   = w_ph + PH_W'(2);
            w_two_n    = {w_n, 1'b0};
            w_boundary = (w_ph_inc >= w_two_n);
            w_d0_nxt   = (w_ph < PH_W'(w_n));
            w_d1_nxt   = ((w_ph + PH_W'(1)) < PH_W'(w_n));
            w_pd_nxt   = w_boundary;
            w_run_nxt  = 1'b1;
            w_act_nxt  = w_n;
            if (w_boundary) begin
                w_ph_nxt = '0;
                if (en) begin
                    w_state_nxt = ST_RUN;
                    w_div_nxt   = w_div_eff;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_div_nxt   = w_n;
                end
            end else begin
                w_state_nxt = ST_RUN;
                w_ph_nxt    = w_ph_inc;
                w_div_nxt   = w_n;
            end
        end
    end

endmodule

// File: tb/tb_fwd_clk_ctrl.sv
// Bench for fwd_clk_ctrl: cycle-level reference model plus directed
// literal sequences and a randomized en/div/reset run.
module tb_fwd_clk_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] div;

    logic       d0_a, d1_a, run_a, pd_a;
    logic [7:0] act_a;
    logic       d0_b, d1_b, run_b, pd_b;
    logic [7:0] act_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fwd_clk_ctrl #(.DIV_WIDTH(8), .IDLE_LEVEL(1'b0)) u_dut_a (
        .clk(clk), .reset(reset), .en(en), .div(div),
        .d0(d0_a), .d1(d1_a), .running(run_a), .period_done(pd_a), .active_div(act_a)
    );

    fwd_clk_ctrl #(.DIV_WIDTH(8), .IDLE_LEVEL(1'b1)) u_dut_b (
        .clk(clk), .reset(reset), .en(en), .div(div),
        .d0(d0_b), .d1(d1_b), .running(run_b), .period_done(pd_b), .active_div(act_b)
    );

    // Reference model: counts whole clk cycles within the output period.
    // Cycle k of a period of N covers half-cycles 2k and 2k+1; the pin is
    // high for the first N half-cycles.
    bit       m_run = 0;
    int       m_pos = 0;
    int       m_n   = 1;
    bit       e_d0 = 0, e_d1 = 0, e_pd = 0, e_run = 0;
    bit [7:0] e_act = 8'd1;
    int       cur_n, cur_pos;
    bit       cur_emit;

    function automatic int eff_div(input logic [7:0] v);
        return (v == 8'd0) ? 1 : int'(v);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_run = 0; m_pos = 0; m_n = 1;
            e_d0 = 0; e_d1 = 0; e_pd = 0; e_run = 0; e_act = 8'd1;
        end else begin
            cur_emit = 1'b1;
            if (m_run) begin
                cur_n = m_n; cur_pos = m_pos;
            end else if (en) begin
                cur_n = eff_div(div); cur_pos = 0;
            end else begin
                cur_emit = 1'b0;
            end
            if (cur_emit) begin
                e_d0  = (2 * cur_pos) < cur_n;
                e_d1  = (2 * cur_pos + 1) < cur_n;
                e_pd  = (cur_pos == cur_n - 1);
                e_run = 1'b1;
                e_act = 8'(cur_n);
                if (cur_pos == cur_n - 1) begin
                    m_pos = 0;
                    m_run = en;
                    m_n   = en ? eff_div(div) : cur_n;
                end else begin
                    m_pos = cur_pos + 1;
                    m_n   = cur_n;
                    m_run = 1'b1;
                end
            end else begin
                e_d0 = 0; e_d1 = 0; e_pd = 0; e_run = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Compare both DUTs against the model; called every cycle.
    task automatic cmp_model();
        chk("model_a", {4'h0, d0_a, d1_a, pd_a, run_a, act_a},
                       {4'h0, e_d0, e_d1, e_pd, e_run, e_act});
        chk("model_b", {4'h0, d0_b, d1_b, pd_b, run_b, act_b},
                       {4'h0, (e_run ? e_d0 : 1'b1), (e_run ? e_d1 : 1'b1), e_pd, e_run, e_act});
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    // Literal expectation applied to DUT A and to the model.
    task automatic lit(input string name, input bit x0, input bit x1, input bit pd,
                       input bit rn, input logic [7:0] act);
        chk(name, {4'h0, d0_a, d1_a, pd_a, run_a, act_a}, {4'h0, x0, x1, pd, rn, act});
        chk({name, "_model"}, {4'h0, e_d0, e_d1, e_pd, e_run, e_act}, {4'h0, x0, x1, pd, rn, act});
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; div = 8'd0;
        @(posedge clk); #1;
        cmp_model();
        reset = 1'b0;

        // Idle after reset, both idle levels
        for (int i = 0; i < 10; i++) begin
            tick();
            lit("idle_a", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
            chk("idle_b", {14'h0, d0_b, d1_b}, 16'h0003);
        end

        // N = 1: forwarded clock equals clk
        en = 1'b1; div = 8'd1;
        tick(); lit("div1_c0", 1, 0, 1, 1, 8'd1);
        tick(); lit("div1_c1", 1, 0, 1, 1, 8'd1);
        en = 1'b0;
        tick(); lit("div1_last", 1, 0, 1, 1, 8'd1);
        tick(); lit("div1_stop", 0, 0, 0, 0, 8'd1);

        // N = 3: odd ratio keeps 50% duty
        do_reset();
        en = 1'b1; div = 8'd3;
        tick(); lit("div3_p0", 1, 1, 0, 1, 8'd3);
        tick(); lit("div3_p1", 1, 0, 0, 1, 8'd3);
        tick(); lit("div3_p2", 0, 0, 1, 1, 8'd3);
        tick(); lit("div3_p3", 1, 1, 0, 1, 8'd3);

        // Ratio change mid-period waits for the boundary
        do_reset();
        en = 1'b1; div = 8'd4;
        tick(); lit("div4_p0", 1, 1, 0, 1, 8'd4);
        tick(); lit("div4_p1", 1, 1, 0, 1, 8'd4);
        div = 8'd2;
        tick(); lit("div4_p2", 0, 0, 0, 1, 8'd4);
        tick(); lit("div4_p3", 0, 0, 1, 1, 8'd4);
        tick(); lit("div2_p0", 1, 1, 0, 1, 8'd2);
        tick(); lit("div2_p1", 0, 0, 1, 1, 8'd2);

        // Stop request mid-period finishes the period first
        do_reset();
        en = 1'b1; div = 8'd5;
        tick(); lit("div5_p0", 1, 1, 0, 1, 8'd5);
        en = 1'b0;
        tick(); lit("div5_p1", 1, 1, 0, 1, 8'd5);
        tick(); lit("div5_p2", 1, 0, 0, 1, 8'd5);
        tick(); lit("div5_p3", 0, 0, 0, 1, 8'd5);
        tick(); lit("div5_p4", 0, 0, 1, 1, 8'd5);
        tick(); lit("div5_idle", 0, 0, 0, 0, 8'd5);

        // en glitch low inside a period does not stop the clock
        en = 1'b1; div = 8'd3;
        tick(); lit("glitch_p0", 1, 1, 0, 1, 8'd3);
        en = 1'b0;
        tick();
        en = 1'b1;
        tick(); lit("glitch_p2", 0, 0, 1, 1, 8'd3);
        tick(); lit("glitch_p3", 1, 1, 0, 1, 8'd3);

        // Reset mid-run truncates; div = 0 then behaves as 1
        do_reset();
        en = 1'b1; div = 8'd6;
        tick(); tick();
        tick(); lit("div6_ph4", 1, 1, 0, 1, 8'd6);
        reset = 1'b1;
        tick(); lit("div6_rst", 0, 0, 0, 0, 8'd1);
        reset = 1'b0; div = 8'd0;
        tick(); lit("div0_run", 1, 0, 1, 1, 8'd1);

        // Randomized en / div / reset traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 9) == 0) div = 8'($urandom_range(0, 40));
                else div = 8'($urandom_range(0, 9));
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; en = 1'b0;
        for (int i = 0; i < 60; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
